// File: rtl/instr_feeder_if.sv
// Host/cpu-side signal bundle for instr_feeder.
// master: the host that loads the program and watches the cpu feed.
// slave:  the feeder itself.
interface instr_feeder_if #(
  parameter int DEPTH = 16,
  parameter int W     = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          start;
  logic          clear;
  logic [W-1:0]  cpu_in;
  logic          cpu_in_valid;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  modport master (
    output wr_valid, wr_data, start, clear,
    input  wr_ready, cpu_in, cpu_in_valid, cpu_reset, busy, done, count
  );

  modport slave (
    input  wr_valid, wr_data, start, clear,
    output wr_ready, cpu_in, cpu_in_valid, cpu_reset, busy, done, count
  );
endinterface

// File: rtl/instr_feeder.sv
// Instruction feeder: buffers a short program from the host, then holds the
// cpu in reset for one cycle and streams the stored bytes into its `in` port,
// one per cycle. The program can be replayed until it is cleared.
module instr_feeder #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic           clk,
  input  logic           reset,
  instr_feeder_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  // rptr points at the next byte to emit, so rptr==count in RUN means the
  // last byte has already been presented.
  logic [CW-1:0] rptr_q, rptr_d;
  logic [W-1:0]  cpu_in_q, cpu_in_d;
  logic          cpu_in_valid_q, cpu_in_valid_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  rd_data;
  logic          wr_ready;
  logic          wr_fire;

  assign wr_ready = (state_q == S_LOAD) && (count_q < DEPTH_C);
  // clear wins over a concurrent write: the byte is not stored.
  assign wr_fire  = bus.wr_valid && wr_ready && !bus.clear;
  assign rd_data  = mem_q[rptr_q[AW-1:0]];

  // Program storage; no reset, contents beyond count are never read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[count_q[AW-1:0]] <= bus.wr_data;
    end
  end

  // Next-state, counters and registered-output values for the coming edge.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    rptr_d         = rptr_q;
    cpu_in_d       = '0;
    cpu_in_valid_d = 1'b0;

    if (bus.clear) begin
      state_d = S_LOAD;
      count_d = '0;
      rptr_d  = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (wr_fire) begin
            count_d = count_q + ONE;
          end
          // A write landing on the same edge makes the buffer non-empty.
          if (bus.start && ((count_q != '0) || wr_fire)) begin
            state_d = S_PRIME;
            rptr_d  = '0;
          end
        end
        S_PRIME: begin
          state_d        = S_RUN;
          cpu_in_d       = rd_data;
          cpu_in_valid_d = 1'b1;
          rptr_d         = rptr_q + ONE;
        end
        S_RUN: begin
          if (rptr_q == count_q) begin
            state_d = S_DONE;
          end else begin
            cpu_in_d       = rd_data;
            cpu_in_valid_d = 1'b1;
            rptr_d         = rptr_q + ONE;
          end
        end
        S_DONE: begin
          if (bus.start) begin
            state_d = S_PRIME;
            rptr_d  = '0;
          end
        end
        default: begin
          state_d = S_LOAD;
          count_d = '0;
          rptr_d  = '0;
        end
      endcase
    end

    cpu_reset_d = (state_d == S_LOAD) || (state_d == S_PRIME);
    busy_d      = (state_d == S_PRIME) || (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers; reset forces the cpu back into reset at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_LOAD;
      count_q        <= '0;
      rptr_q         <= '0;
      cpu_in_q       <= '0;
      cpu_in_valid_q <= 1'b0;
      cpu_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rptr_q         <= rptr_d;
      cpu_in_q       <= cpu_in_d;
      cpu_in_valid_q <= cpu_in_valid_d;
      cpu_reset_q    <= cpu_reset_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.wr_ready     = wr_ready;
  assign bus.cpu_in       = cpu_in_q;
  assign bus.cpu_in_valid = cpu_in_valid_q;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder.
module tb_instr_feeder;
  localparam int DEPTH = 16;
  localparam int W     = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_feeder_if #(.DEPTH(DEPTH), .W(W)) bus ();

  instr_feeder #(.DEPTH(DEPTH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full output picture for an idle (non-RUN) state.
  task automatic chk_idle(input string tag, input logic exp_rst, input logic exp_busy,
                          input logic exp_done);
    chk({tag, "_valid"},  32'(bus.cpu_in_valid), 32'd0);
    chk({tag, "_cpuin"},  32'(bus.cpu_in),       32'd0);
    chk({tag, "_cpurst"}, 32'(bus.cpu_reset),    32'(exp_rst));
    chk({tag, "_busy"},   32'(bus.busy),         32'(exp_busy));
    chk({tag, "_done"},   32'(bus.done),         32'(exp_done));
  endtask

  task automatic chk_run(input string tag, input logic [7:0] exp_byte);
    chk({tag, "_valid"},  32'(bus.cpu_in_valid), 32'd1);
    chk({tag, "_cpuin"},  32'(bus.cpu_in),       32'(exp_byte));
    chk({tag, "_cpurst"}, 32'(bus.cpu_reset),    32'd0);
    chk({tag, "_busy"},   32'(bus.busy),         32'd1);
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.clear    = 1'b0;

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk_idle("rst", 1'b1, 1'b0, 1'b0);
    chk("rst_count", 32'(bus.count), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_wrready", 32'(bus.wr_ready), 32'd1);

    // Basic playback 6F 01 3D, with a start pulse during RUN ignored
    wr_byte(8'h6F);
    wr_byte(8'h01);
    wr_byte(8'h3D);
    chk("basic_count", 32'(bus.count), 32'd3);
    pulse_start();
    chk_idle("basic_prime", 1'b1, 1'b1, 1'b0);
    chk("basic_prime_wrready", 32'(bus.wr_ready), 32'd0);
    tick();
    chk_run("basic_b0", 8'h6F);
    pulse_start();
    chk_run("basic_b1", 8'h01);
    tick();
    chk_run("basic_b2", 8'h3D);
    tick();
    chk_idle("basic_done", 1'b0, 1'b0, 1'b1);
    tick();
    chk_idle("basic_done2", 1'b0, 1'b0, 1'b1);
    pulse_clear();
    chk_idle("clr", 1'b1, 1'b0, 1'b0);
    chk("clr_count", 32'(bus.count), 32'd0);
    chk("clr_wrready", 32'(bus.wr_ready), 32'd1);

    // Full buffer: 17 writes, the last one dropped
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("full_wrready%0d", i), 32'(bus.wr_ready), (i < 16) ? 32'd1 : 32'd0);
      wr_byte(8'(i));
    end
    chk("full_count", 32'(bus.count), 32'd16);
    chk("full_wrready_end", 32'(bus.wr_ready), 32'd0);
    pulse_start();
    chk_idle("full_prime", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_run($sformatf("full_b%0d", i), 8'(i));
    end
    tick();
    chk_idle("full_done", 1'b0, 1'b0, 1'b1);
    chk("full_done_count", 32'(bus.count), 32'd16);
    pulse_clear();

    // Simultaneous write and start from empty
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hB2;
    bus.start    = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    chk_idle("sim_prime", 1'b1, 1'b1, 1'b0);
    chk("sim_count", 32'(bus.count), 32'd1);
    tick();
    chk_run("sim_b0", 8'hB2);
    tick();
    chk_idle("sim_done", 1'b0, 1'b0, 1'b1);
    pulse_clear();

    // Empty start ignored, then replay
    pulse_start();
    chk_idle("empty_start", 1'b1, 1'b0, 1'b0);
    chk("empty_wrready", 32'(bus.wr_ready), 32'd1);
    tick();
    chk_idle("empty_start2", 1'b1, 1'b0, 1'b0);
    wr_byte(8'h15);
    pulse_start();
    chk_idle("rep_prime", 1'b1, 1'b1, 1'b0);
    tick();
    chk_run("rep_b0", 8'h15);
    tick();
    chk_idle("rep_done", 1'b0, 1'b0, 1'b1);
    pulse_start();
    chk_idle("rep_prime2", 1'b1, 1'b1, 1'b0);
    tick();
    chk_run("rep_b0_again", 8'h15);
    tick();
    chk_idle("rep_done2", 1'b0, 1'b0, 1'b1);

    // Clear and start together in DONE
    bus.clear = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk_idle("cp_load", 1'b1, 1'b0, 1'b0);
    chk("cp_count", 32'(bus.count), 32'd0);
    tick();
    chk_idle("cp_load2", 1'b1, 1'b0, 1'b0);

    // Reset asserted during the 2nd of 4 RUN bytes
    wr_byte(8'hAA);
    wr_byte(8'hBB);
    wr_byte(8'hCC);
    wr_byte(8'hDD);
    pulse_start();
    tick();
    chk_run("mr_b0", 8'hAA);
    tick();
    chk_run("mr_b1", 8'hBB);
    #2 reset = 1'b0;
    #1;
    chk_idle("mr_async", 1'b1, 1'b0, 1'b0);
    chk("mr_count", 32'(bus.count), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mr_wrready", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle($sformatf("mr_after%0d", i), 1'b1, 1'b0, 1'b0);
    end
    chk("mr_count_end", 32'(bus.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16: program buffer depth in bytes.
REQ-002 SHALL have parameter W, default 8: byte width, matching the cpu `in` port.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1: host offers a program byte.
REQ-006 SHALL have port wr_data  input  W: program byte.
REQ-007 SHALL have port wr_ready  output  1: buffer accepts a byte this cycle.
REQ-008 SHALL have port start  input  1: single-cycle pulse that begins or replays playback.
REQ-009 SHALL have port clear  input  1: discards the program and returns to LOAD.
REQ-010 SHALL have port cpu_in  output  W: byte driven to the cpu `in` port.
REQ-011 SHALL have port cpu_in_valid  output  1: cpu_in carries a program byte.
REQ-012 SHALL have port cpu_reset  output  1: active-high reset to the cpu.
REQ-013 SHALL have port busy  output  1: high in PRIME or RUN.
REQ-014 SHALL have port done  output  1: high in DONE.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1: number of bytes stored.

Function
REQ-016 SHALL implement four states: LOAD, PRIME, RUN and DONE.
REQ-017 SHALL register all outputs; no output is combinational from an input except wr_ready, which depends only on state and count.
REQ-018 SHALL drive wr_ready = (state==LOAD) && (count<DEPTH).
REQ-019 SHALL, when wr_valid && wr_ready, write wr_data at index count and increment count by 1 on that edge.
REQ-020 SHALL ignore wr_valid outside LOAD or when the buffer is full (count==DEPTH); the byte is dropped and count is unchanged.
REQ-021 SHALL, in LOAD with start=1 and count>0 (count including any write accepted on the same edge), go to PRIME.
REQ-022 SHALL ignore start in LOAD while count==0 and no write is accepted that cycle.
REQ-023 SHALL hold cpu_reset=1 for exactly 1 cycle in PRIME, with read pointer rptr=0, then go to RUN.
REQ-024 SHALL, in RUN, drive cpu_in=buf[rptr] and cpu_in_valid=1 each cycle, incrementing rptr.
REQ-025 SHALL produce exactly count consecutive RUN cycles, then go to DONE after the cycle with rptr==count-1.
REQ-026 SHALL set first-byte latency to 2 cycles: start sampled at edge k puts cpu_reset=1 after edge k, and cpu_in=buf[0] with valid after edge k+1.
REQ-027 SHALL drive cpu_reset=1 in LOAD and PRIME, and cpu_reset=0 in RUN and DONE.
REQ-028 SHALL drive cpu_in=0 and cpu_in_valid=0 in every state other than RUN.
REQ-029 SHALL, on start in DONE, go to PRIME and replay the same program unchanged.
REQ-030 SHALL, on clear in any state, go to LOAD on the next edge with count=0 and rptr=0; clear has priority over start and wr_valid.
REQ-031 SHALL ignore start pulses during PRIME or RUN; playback is not restarted.
REQ-032 SHALL leave buffer contents undefined after clear or reset; they are never read beyond count.

Reset
REQ-033 SHALL, on reset low, immediately set state=LOAD, count=0, rptr=0, cpu_in=0, cpu_in_valid=0, cpu_reset=1, busy=0 and done=0, regardless of clock.
REQ-034 SHALL, on reset asserted mid-RUN, stop playback within the same cycle and raise cpu_reset asynchronously.
REQ-035 SHALL resume normal operation from the first rising clk edge after reset deasserts; wr_ready=1 immediately after deassertion.

Verification
REQ-036 Basic playback: load 0x6F, 0x01, 0x3D, pulse start -> one cycle cpu_reset=1, then cpu_in = 0x6F, 0x01, 0x3D with valid on three consecutive cycles, then done=1 and cpu_in=0.
REQ-037 Full buffer: write 17 bytes 0x00..0x10 -> wr_ready drops after the 16th write, count=16, 0x10 is dropped, and playback emits 0x00..0x0F.
REQ-038 Simultaneous write and start: a single write of 0xB2 with start on the same edge from empty -> PRIME, then one RUN byte 0xB2, then DONE.
REQ-039 Empty start and replay: start with count=0 -> stays in LOAD with busy=0; after load of 0x15 and playback to DONE, start again -> 0x15 replayed once more.
REQ-040 Reset mid-operation: reset low during the 2nd of 4 RUN bytes -> cpu_in=0, valid=0 and cpu_reset=1 immediately, count=0, and no further bytes are emitted.
REQ-041 Clear priority: clear and start together in DONE -> LOAD with count=0, and no PRIME cycle occurs.
